// File: rtl/demux32_4_buf_pkg.sv
`default_nettype none
// ============================================================================
// Module      : demux32_4_buf_pkg
// Description : Shared constants and types for the buffered 1-to-4 demux.
//               c_num_ch     - number of output channels
//               c_sel_w      - width of the channel select
//               c_def_width  - default data path width
//               c_def_cntw   - default accepted-transfer counter width
//               slot_state_t - per-channel holding slot state
// Revision    : 1.0 - initial release
// ============================================================================
package demux32_4_buf_pkg;

    localparam int c_num_ch    = 4;
    localparam int c_sel_w     = 2;
    localparam int c_def_width = 32;
    localparam int c_def_cntw  = 16;

    typedef enum logic [0:0] {
        SLOT_EMPTY = 1'b0,
        SLOT_FULL  = 1'b1
    } slot_state_t;

endpackage : demux32_4_buf_pkg
`default_nettype wire

// File: rtl/demux32_4_buf_slot.sv
`default_nettype none
// ============================================================================
// Module      : demux_slot
// Description : One-entry holding slot for a single demux output channel.
//               A load always wins over an unload at the same edge, so a
//               channel can take a new word in the same cycle its consumer
//               drains the old one (one word per cycle per channel).
// Ports       : clk         - clock
//               reset       - asynchronous active-low reset
//               i_load      - write i_load_data into the slot this edge
//               i_load_data - word to store
//               i_unload    - consumer takes the held word this edge
//               o_data      - held word (stable while full and not taken)
//               o_valid     - slot is FULL
// Revision    : 1.0 - initial release
// ============================================================================
module demux_slot
    import demux32_4_buf_pkg::*;
#(
    parameter int WIDTH = c_def_width
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             i_load,
    input  logic [WIDTH-1:0] i_load_data,
    input  logic             i_unload,
    output logic [WIDTH-1:0] o_data,
    output logic             o_valid
);

    slot_state_t      r_state;
    logic [WIDTH-1:0] r_data;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_state <= SLOT_EMPTY;
            r_data  <= '0;
        end else begin
            case (r_state)
                SLOT_EMPTY: begin
                    if (i_load) begin
                        r_state <= SLOT_FULL;
                        r_data  <= i_load_data;
                    end
                end
                SLOT_FULL: begin
                    // Data is left in place when draining; its value is
                    // don't-care once the slot is empty.
                    if (i_load) begin
                        r_data <= i_load_data;
                    end else if (i_unload) begin
                        r_state <= SLOT_EMPTY;
                    end
                end
                default: r_state <= SLOT_EMPTY;
            endcase
        end
    end

    assign o_data  = r_data;
    assign o_valid = (r_state == SLOT_FULL);

endmodule : demux_slot
`default_nettype wire

// File: rtl/demux32_4_buf.sv
`default_nettype none
// ============================================================================
// Module      : demux32_4_buf
// Description : Buffered 1-to-4 demultiplexer. Each channel owns a one-entry
//               slot; a word offered on the input is routed to the slot
//               chosen by in_select. The input is ready when the selected
//               slot is empty or is being drained in the same cycle.
// Ports       : clk       - clock
//               reset     - asynchronous active-low reset
//               in_data   - word to route
//               in_select - destination channel 0..3
//               in_valid  - in_data/in_select are valid
//               in_ready  - the offered word is accepted this cycle
//               out_data  - channel i at [i*WIDTH +: WIDTH]
//               out_valid - bit i: channel i holds a word
//               out_ready - bit i: channel i consumer takes its word
//               count     - words accepted since reset (wraps silently)
// Revision    : 1.0 - initial release
// ============================================================================
module demux32_4_buf
    import demux32_4_buf_pkg::*;
#(
    parameter int WIDTH = c_def_width,
    parameter int CNTW  = c_def_cntw
) (
    input  logic                      clk,
    input  logic                      reset,
    input  logic [WIDTH-1:0]          in_data,
    input  logic [c_sel_w-1:0]        in_select,
    input  logic                      in_valid,
    output logic                      in_ready,
    output logic [c_num_ch*WIDTH-1:0] out_data,
    output logic [c_num_ch-1:0]       out_valid,
    input  logic [c_num_ch-1:0]       out_ready,
    output logic [CNTW-1:0]           count
);

    logic [c_num_ch-1:0] w_valid;
    logic                w_accept;
    logic [CNTW-1:0]     r_count;

    // in_ready deliberately ignores in_valid so no path exists from
    // in_valid to any output.
    assign in_ready = !w_valid[in_select] || out_ready[in_select];
    assign w_accept = in_valid && in_ready;

    generate
        for (genvar i = 0; i < c_num_ch; i++) begin : g_slot
            logic w_load;

            assign w_load = w_accept && (in_select == c_sel_w'(i));

            demux_slot #(
                .WIDTH (WIDTH)
            ) u_slot (
                .clk         (clk),
                .reset       (reset),
                .i_load      (w_load),
                .i_load_data (in_data),
                .i_unload    (out_ready[i]),
                .o_data      (out_data[i*WIDTH +: WIDTH]),
                .o_valid     (w_valid[i])
            );
        end
    endgenerate

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_count <= '0;
        end else if (w_accept) begin
            r_count <= r_count + {{(CNTW-1){1'b0}}, 1'b1};
        end
    end

    assign out_valid = w_valid;
    assign count     = r_count;

endmodule : demux32_4_buf
`default_nettype wire

// File: tb/tb_demux32_4_buf.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
// Module      : tb_demux32_4_buf
// Description : Self-checking bench for demux32_4_buf. Two instances share
//               the stimulus: one with default parameters and one with a
//               4-bit counter to exercise wrap-around. A queue-per-channel
//               reference model is compared every cycle, and directed
//               scenarios add literal expectations.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_demux32_4_buf;

    logic         clk       = 1'b0;
    logic         reset     = 1'b0;
    logic [31:0]  in_data   = '0;
    logic [1:0]   in_select = '0;
    logic         in_valid  = 1'b0;
    logic [3:0]   out_ready = '0;

    wire          in_ready;
    wire  [127:0] out_data;
    wire  [3:0]   out_valid;
    wire  [15:0]  count;

    wire          in_ready_w;
    wire  [127:0] out_data_w;
    wire  [3:0]   out_valid_w;
    wire  [3:0]   count_w;

    demux32_4_buf dut (
        .clk       (clk),
        .reset     (reset),
        .in_data   (in_data),
        .in_select (in_select),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .out_data  (out_data),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .count     (count)
    );

    demux32_4_buf #(.WIDTH(32), .CNTW(4)) dut_w (
        .clk       (clk),
        .reset     (reset),
        .in_data   (in_data),
        .in_select (in_select),
        .in_valid  (in_valid),
        .in_ready  (in_ready_w),
        .out_data  (out_data_w),
        .out_valid (out_valid_w),
        .out_ready (out_ready),
        .count     (count_w)
    );

    always #5 clk = ~clk;

    int          n_tests  = 0;
    int          n_fail   = 0;
    bit          check_en = 1'b0;
    logic [31:0] mq[4][$];
    int          mcount   = 0;
    bit          m_acc;

    function automatic bit model_ready();
        return (mq[in_select].size() == 0) || out_ready[in_select];
    endfunction

    task automatic check(input string name, input logic [127:0] act, input logic [127:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // Reference model: each channel is a queue of at most one word.
    always @(posedge clk or negedge reset) begin
        if (!reset) begin
            for (int i = 0; i < 4; i++) mq[i].delete();
            mcount = 0;
        end else begin
            m_acc = in_valid && model_ready();
            for (int i = 0; i < 4; i++)
                if (mq[i].size() != 0 && out_ready[i]) void'(mq[i].pop_front());
            if (m_acc) begin
                mq[in_select].push_back(in_data);
                mcount++;
            end
        end
    end

    // Per-cycle comparison, mid low phase: registered outputs settled and
    // inputs for the coming edge already applied.
    always @(negedge clk) begin
        if (check_en) begin
            #3;
            for (int i = 0; i < 4; i++) begin
                check($sformatf("model valid ch%0d", i), out_valid[i], mq[i].size() != 0);
                if (mq[i].size() != 0)
                    check($sformatf("model data ch%0d", i), out_data[i*32 +: 32], mq[i][0]);
            end
            check("model count", count, mcount[15:0]);
            check("model count4", count_w, mcount[3:0]);
            check("model in_ready", in_ready, model_ready());
            check("model in_ready4", in_ready_w, model_ready());
        end
    end

    task automatic cyc();
        @(negedge clk);
        #1;
    endtask

    task automatic do_reset();
        @(posedge clk);
        #2;
        reset = 1'b0;
        @(posedge clk);
        @(negedge clk);
        #1;
        reset = 1'b1;
    endtask

    task automatic offer(input logic v, input logic [1:0] s, input logic [31:0] d);
        in_valid  = v;
        in_select = s;
        in_data   = d;
    endtask

    initial begin
        repeat (2) @(posedge clk);
        @(negedge clk);
        #1;
        reset    = 1'b1;
        check_en = 1'b1;

        // Reset state
        #1;
        check("reset out_valid", out_valid, 4'b0000);
        check("reset count", count, 16'd0);
        check("reset in_ready", in_ready, 1'b1);
        check("reset out_data", out_data, 128'd0);

        // Single route to channel 2
        offer(1'b1, 2'd2, 32'h12345678);
        out_ready = 4'b0000;
        cyc();
        offer(1'b0, 2'd0, 32'h0);
        check("route out_valid", out_valid, 4'b0100);
        check("route ch2 data", out_data[95:64], 32'h12345678);
        check("route count", count, 16'd1);

        // Backpressure on channel 1
        offer(1'b1, 2'd1, 32'hAAAA0001);
        cyc();
        offer(1'b1, 2'd1, 32'hBBBB0002);
        #1;
        check("bp in_ready low", in_ready, 1'b0);
        for (int k = 0; k < 5; k++) begin
            cyc();
            check("bp in_ready held", in_ready, 1'b0);
            check("bp ch1 stable", out_data[63:32], 32'hAAAA0001);
        end
        out_ready = 4'b0010;
        #1;
        check("bp in_ready release", in_ready, 1'b1);
        cyc();
        offer(1'b0, 2'd0, 32'h0);
        out_ready = 4'b0000;
        check("bp ch1 new data", out_data[63:32], 32'hBBBB0002);
        check("bp ch1 valid", out_valid[1], 1'b1);

        // Streaming 0..7 into channel 0
        do_reset();
        out_ready = 4'b0001;
        for (int k = 0; k < 8; k++) begin
            offer(1'b1, 2'd0, 32'(k));
            #1;
            check("stream in_ready", in_ready, 1'b1);
            cyc();
            check("stream ch0 valid", out_valid[0], 1'b1);
            check("stream ch0 data", out_data[31:0], 32'(k));
        end
        offer(1'b0, 2'd0, 32'h0);
        check("stream count", count, 16'd8);

        // Independence: channel 3 stalled while 0..2 load
        do_reset();
        out_ready = 4'b0000;
        offer(1'b1, 2'd3, 32'hC3C3C3C3);
        cyc();
        for (int c = 0; c < 3; c++) begin
            offer(1'b1, 2'(c), 32'hD0D0_0000 + 32'(c));
            #1;
            check("indep in_ready", in_ready, 1'b1);
            cyc();
        end
        offer(1'b0, 2'd0, 32'h0);
        check("indep out_valid", out_valid, 4'b1111);
        check("indep ch3 data", out_data[127:96], 32'hC3C3C3C3);
        check("indep ch1 data", out_data[63:32], 32'hD0D00001);

        // Counter wrap on the 4-bit instance
        do_reset();
        out_ready = 4'b1111;
        for (int k = 0; k < 17; k++) begin
            offer(1'b1, 2'($urandom_range(0, 3)), $urandom);
            cyc();
        end
        check("wrap count4", count_w, 4'd1);
        check("wrap count16", count, 16'd17);

        // Asynchronous reset with full slots
        out_ready = 4'b0000;
        offer(1'b1, 2'd0, 32'h11110000);
        cyc();
        offer(1'b1, 2'd1, 32'h22220000);
        cyc();
        @(posedge clk);
        #2;
        reset = 1'b0;
        #1;
        check("async out_valid", out_valid, 4'b0000);
        check("async count", count, 16'd0);
        check("async count4", count_w, 4'd0);
        check("async out_data", out_data, 128'd0);
        @(posedge clk);
        @(negedge clk);
        #1;
        reset = 1'b1;
        #1;
        check("post-reset out_valid", out_valid, 4'b0000);
        check("post-reset count", count, 16'd0);
        offer(1'b0, 2'd2, 32'h0);
        #1;
        check("post-reset in_ready", in_ready, 1'b1);

        // Randomised traffic
        for (int k = 0; k < 400; k++) begin
            offer(1'($urandom_range(0, 1)), 2'($urandom_range(0, 3)), $urandom);
            out_ready = 4'($urandom);
            cyc();
        end

        check_en = 1'b0;
        offer(1'b0, 2'd0, 32'h0);
        #5;
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL timeout: simulation did not finish");
        $fatal(1, "timeout");
    end

endmodule : tb_demux32_4_buf
`default_nettype wire

// File: doc/demux32_4_buf.md
DEMUX32_4_BUF -- requirements
Module: demux32_4_buf

Interface
REQ-001 SHALL take parameter WIDTH, default 32, giving the data path width in bits.
REQ-002 SHALL take parameter CNTW, default 16, giving the accepted-transfer counter width in bits.
REQ-003 SHALL have port clk, input, 1 bit: the single clock; all state updates on the rising edge.
REQ-004 SHALL have port reset, input, 1 bit: one clock; reset is asynchronous and active-low.
REQ-005 SHALL have port in_data, input, WIDTH bits: the word to route.
REQ-006 SHALL have port in_select, input, 2 bits: destination channel index, 0 to 3.
REQ-007 SHALL have port in_valid, input, 1 bit: in_data and in_select are valid.
REQ-008 SHALL have port in_ready, output, 1 bit: the block accepts the offered word this cycle.
REQ-009 SHALL have port out_data, output, 4*WIDTH bits: channel i occupies bits [i*WIDTH +: WIDTH].
REQ-010 SHALL have port out_valid, output, 4 bits: bit i means channel i holds a word.
REQ-011 SHALL have port out_ready, input, 4 bits: bit i means the channel i consumer takes the word.
REQ-012 SHALL have port count, output, CNTW bits: total words accepted since reset.

Function
REQ-013 SHALL give each channel a one-entry holding slot with two states: EMPTY (out_valid[i]=0) and FULL (out_valid[i]=1).
REQ-014 SHALL define an input transfer as in_valid=1 and in_ready=1 at a rising edge.
REQ-015 SHALL define an output transfer on channel i as out_valid[i]=1 and out_ready[i]=1 at a rising edge.
REQ-016 SHALL drive in_ready combinationally as (slot[in_select] EMPTY) OR out_ready[in_select].
- in_ready is independent of in_valid.
- in_ready depends on out_ready of the selected channel only.
REQ-017 SHALL, on an input transfer, load in_data into slot[in_select] and set that slot FULL at the same edge.
- Latency is one cycle from input transfer to out_valid.
REQ-018 SHALL, on an output transfer on channel i with no simultaneous load of channel i, set slot i EMPTY.
REQ-019 SHALL, when channel i has an output transfer and a load at the same edge, keep slot i FULL with the new data.
- This gives back-to-back throughput of one word per cycle per channel.
REQ-020 SHALL hold out_data for channel i stable while out_valid[i]=1 and out_ready[i]=0.
REQ-021 SHALL leave non-selected channels unaffected by input activity.
- Their slots change only through their own output transfers.
REQ-022 SHALL ignore in_data and in_select whenever in_valid=0.
REQ-023 SHALL leave out_data of a channel unchanged when that slot goes EMPTY; the value there is don't-care.
REQ-024 SHALL increment count by one on every input transfer.
- count wraps from 2^CNTW-1 to 0 with no flag.
REQ-025 SHALL create no combinational path from in_valid to any output.

Reset
REQ-026 SHALL, when reset=0, immediately and asynchronously force all slots EMPTY, out_valid=0, out_data=0 and count=0.
REQ-027 SHALL discard any word held or offered when reset asserts mid-operation.
REQ-028 SHALL accept no input transfer in a cycle where reset=0 at the edge.
REQ-029 SHALL give in_ready=1 in the first cycle after reset deasserts, because all slots are EMPTY.

Structure
REQ-030 SHALL place in a shared package: channel count (4), select width (2), default WIDTH (32), default CNTW (16).
REQ-031 SHALL implement each slot as sub-module demux_slot.
- demux_slot contains one WIDTH register, one valid flag, and the load/unload logic of REQ-017 to REQ-019.
- demux_slot is instantiated four times.
REQ-032 SHALL keep the routing decode and count in the top module.

Verification
REQ-033 SHALL cover single route: after reset, in_data=0x12345678, in_select=2, in_valid=1 for 1 cycle, out_ready=0000.
- Next cycle: out_valid=0100, channel 2 data=0x12345678, count=1.
REQ-034 SHALL cover backpressure: channel 1 FULL with 0xAAAA0001, out_ready[1]=0, offer 0xBBBB0002 to select 1.
- in_ready=0 and channel 1 data stays 0xAAAA0001 for 5 cycles.
- Raise out_ready[1]: in_ready=1, and the next cycle channel 1 data=0xBBBB0002.
REQ-035 SHALL cover streaming: 8 consecutive words 0..7 to channel 0 with out_ready[0]=1 throughout.
- One word out per cycle, in order, in_ready never 0, count=8.
REQ-036 SHALL cover independence: channel 3 FULL and stalled, then words sent to channels 0, 1, 2.
- All three are accepted immediately and channel 3 data is unchanged.
REQ-037 SHALL cover wrap and reset: with CNTW=4, accept 17 words and check count=1.
- Assert reset mid-stream with slots FULL: out_valid=0000 and count=0 without waiting for a clock edge.
